// File: rtl/dallanma_paket.sv
// Purpose: shared definitions for the branch predictor (counter encodings, table size default).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dallanma_paket;

    typedef logic [1:0] sayac_t;

    // 2-bit saturating counter states; bit 1 is the taken/not-taken decision.
    localparam sayac_t GA = 2'b00; // strong not-taken
    localparam sayac_t ZA = 2'b01; // weak not-taken
    localparam sayac_t ZT = 2'b10; // weak taken
    localparam sayac_t GT = 2'b11; // strong taken

    localparam int     BHT_GIRDI_VARSAYILAN = 64;
    localparam sayac_t SAYAC_RESET          = ZA;

endpackage

// File: rtl/doygun_sayac.sv
// Purpose: next-state logic of one 2-bit saturating counter.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
// Ports: sayac_i current counter, atladi_i branch taken, sonraki_o next counter value.
module doygun_sayac
    import dallanma_paket::*;
(
    input  logic [1:0] sayac_i,
    input  logic       atladi_i,
    output logic [1:0] sonraki_o
);

    always_comb begin
        sonraki_o = sayac_i;
        if (atladi_i) begin
            if (sayac_i != GT) begin
                sonraki_o = sayac_i + 2'd1;
            end
        end else begin
            if (sayac_i != GA) begin
                sonraki_o = sayac_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/dallanma_ongorucu.sv
// Purpose: bimodal (or gshare with GSHARE_EN defined) branch predictor with 2-bit counters.
// Latency: prediction combinational (0 cycles); update visible from the cycle after it is applied.
// Backpressure: none; one prediction and one update accepted every cycle.
// Ports: clk_i/rst_i clock and sync active-high reset; ps_i/ps_gecerli_i fetch PC;
//        dallanma_ongorusu_o/ongoru_gecmis_o prediction and history snapshot;
//        guncelle_* resolved-branch update carrying back its history snapshot.
// Config macro: GSHARE_EN adds an IDX-bit global history XORed into both indices.
module dallanma_ongorucu
    import dallanma_paket::*;
#(
    parameter  int BHT_GIRDI = BHT_GIRDI_VARSAYILAN,
    localparam int IDX       = $clog2(BHT_GIRDI)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [31:0]    ps_i,
    input  logic           ps_gecerli_i,
    output logic           dallanma_ongorusu_o,
    output logic [IDX-1:0] ongoru_gecmis_o,
    input  logic           guncelle_gecerli_i,
    input  logic           guncelle_atladi_i,
    input  logic [31:0]    guncelle_ps_i,
    input  logic [IDX-1:0] guncelle_gecmis_i
);

    sayac_t         tablo [BHT_GIRDI];
    logic [IDX-1:0] oku_idx;
    logic [IDX-1:0] yaz_idx;
    sayac_t         yeni_sayac;

`ifdef GSHARE_EN
    logic [IDX-1:0] ghr;

    assign oku_idx = ps_i[IDX+1:2] ^ ghr;
    assign yaz_idx = guncelle_ps_i[IDX+1:2] ^ guncelle_gecmis_i;

    // Output gated during reset: ghr is only cleared at the reset edge.
    assign ongoru_gecmis_o = rst_i ? '0 : ghr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ghr <= '0;
        end else if (guncelle_gecerli_i) begin
            ghr <= {ghr[IDX-2:0], guncelle_atladi_i};
        end
    end

    logic unused_bitler;
    assign unused_bitler = ^{ps_i[31:IDX+2], ps_i[1:0],
                             guncelle_ps_i[31:IDX+2], guncelle_ps_i[1:0]};
`else
    assign oku_idx         = ps_i[IDX+1:2];
    assign yaz_idx         = guncelle_ps_i[IDX+1:2];
    assign ongoru_gecmis_o = '0;

    // History input has no meaning in the pure bimodal build.
    logic unused_bitler;
    assign unused_bitler = ^{guncelle_gecmis_i, ps_i[31:IDX+2], ps_i[1:0],
                             guncelle_ps_i[31:IDX+2], guncelle_ps_i[1:0]};
`endif

    // Reads the array directly, so a same-cycle update at this index is not seen yet.
    assign dallanma_ongorusu_o = ps_gecerli_i && !rst_i && tablo[oku_idx][1];

    doygun_sayac u_doygun_sayac (
        .sayac_i   (tablo[yaz_idx]),
        .atladi_i  (guncelle_atladi_i),
        .sonraki_o (yeni_sayac)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BHT_GIRDI; i++) begin
                tablo[i] <= SAYAC_RESET;
            end
        end else if (guncelle_gecerli_i) begin
            tablo[yaz_idx] <= yeni_sayac;
        end
    end

endmodule
